// File: rtl/button_event_fsm_if.sv
// Button event bundle: the debounced level and enable going in, the one-cycle
// UI strobes, hold flag, press counter and FSM state coming out.
//
// Handshake: there is no backpressure. Every *_pulse is a one-cycle strobe
// that acts as its own valid; consumers must take it in the cycle it is high,
// and at most one strobe is high in any cycle. en/level_in are sampled on
// every posedge of clk.
interface button_event_fsm_if;
  logic       en;
  logic       level_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;
  logic [1:0] state_dbg;

  // Driver of the button level / enable (testbench or upstream debouncer side)
  modport master (
    output en,
    output level_in,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held,
    input  press_count,
    input  state_dbg
  );

  // The event FSM itself
  modport slave (
    input  en,
    input  level_in,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held,
    output press_count,
    output state_dbg
  );
endinterface

// File: rtl/button_event_fsm.sv
// Turns a clean button level into registered one-cycle press, release,
// long-press and auto-repeat strobes, plus a wrapping 8-bit press counter.
// A level that is already high (after reset or after en drops) must go low
// before a press can be accepted, which is what WAIT_LOW enforces.
module button_event_fsm #(
  parameter int LONG_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  button_event_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  // Next-state, counter and strobe decode; release takes priority over the
  // hold counter firing, so at most one strobe is ever requested.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!bus.en) begin
      state_d = WAIT_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOW: begin
          cnt_d = '0;
          if (!bus.level_in) state_d = IDLE;
        end
        IDLE: begin
          cnt_d = '0;
          if (bus.level_in) begin
            state_d = PRESSED;
            press_d = 1'b1;
            count_d = count_q + 8'd1;
          end
        end
        PRESSED: begin
          if (!bus.level_in) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG: begin
          if (!bus.level_in) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, hold counter, press counter and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // held comes straight from the state register, so it is glitch-free
  assign bus.held          = (state_q == PRESSED) || (state_q == LONG);
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.press_count   = count_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm with LONG_CYCLES=5, REPEAT_CYCLES=3.
// Stimulus pushes expected events {cycle, strobe vector, press_count} into a
// queue; a negedge monitor pops one entry whenever any strobe is high.
module tb_button_event_fsm;
  localparam int LONG_CYCLES   = 5;
  localparam int REPEAT_CYCLES = 3;
  localparam int W             = 32;

  // strobe vector order: {press, release, long, repeat}
  localparam logic [3:0] EV_PRESS = 4'b1000;
  localparam logic [3:0] EV_REL   = 4'b0100;
  localparam logic [3:0] EV_LONG  = 4'b0010;
  localparam logic [3:0] EV_REP   = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [7:0]    exp_count;
  logic [3:0]    mon_ev;
  logic [W-1:0]  mon_got;
  logic [W-1:0]  mon_exp;

  button_event_fsm_if bus();

  button_event_fsm #(
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  always @(negedge clk) begin
    mon_ev = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
    if (mon_ev != 4'b0000) begin
      checks++;
      mon_got = {cyc[19:0], mon_ev, bus.press_count};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d ev=%b count=%0d, required no event",
                 cyc, mon_ev, bus.press_count);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
        begin
          errors++;
          $display("FAIL event: got cyc=%0d ev=%b count=%0d, required cyc=%0d ev=%b count=%0d",
                   mon_got[31:12], mon_got[11:8], mon_got[7:0],
                   mon_exp[31:12], mon_exp[11:8], mon_exp[7:0]);
        end
      end
    end
  end

  function automatic void push(input logic [3:0] ev, input int at);
    exp_q.push_back({at[19:0], ev, exp_count});
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // driver: inputs change on the negedge, sampled by the next posedge
  task automatic step(input logic e, input logic l);
    @(negedge clk);
    bus.en       = e;
    bus.level_in = l;
  endtask

  // From IDLE: level high for h drives, then low. Expectations follow the
  // latencies: press 1 cycle after the first high sample, long LONG_CYCLES
  // later, repeats every REPEAT_CYCLES, release 1 cycle after the low sample.
  task automatic press_hold(input int h);
    int c;
    step(1'b1, 1'b1);
    c = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_PRESS, c + 1);
    if (h >= LONG_CYCLES + 1) begin
      push(EV_LONG, c + LONG_CYCLES + 1);
      for (int k = 1; REPEAT_CYCLES * k <= h - LONG_CYCLES - 1; k++)
        push(EV_REP, c + LONG_CYCLES + 1 + REPEAT_CYCLES * k);
    end
    push(EV_REL, c + h + 1);
    repeat (h - 1) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("held_during_press", int'(bus.held), 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    exp_count = 8'd0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.level_in = 1'b0;
    exp_count    = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_held", int'(bus.held), 0);
    check("reset_count", int'(bus.press_count), 0);
    check("reset_state", int'(bus.state_dbg), 0);
    rst = 1'b0;

    // leave WAIT_LOW
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("idle_state", int'(bus.state_dbg), 1);

    // short press: 3 cycles held, no long
    press_hold(3);
    step(1'b1, 1'b0);
    check("held_after_short", int'(bus.held), 0);
    check("count_after_short", int'(bus.press_count), 1);

    // long hold: press, long, two repeats, release
    press_hold(13);
    step(1'b1, 1'b0);

    // release on the edge where PRESSED would fire long
    press_hold(5);
    step(1'b1, 1'b0);
    // release on the edge where LONG would fire repeat
    press_hold(8);
    step(1'b1, 1'b0);
    check("count_after_races", int'(bus.press_count), 4);

    // reset mid-hold in LONG, level kept high through and after reset
    step(1'b1, 1'b1);
    c = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_PRESS, c + 1);
    push(EV_LONG, c + LONG_CYCLES + 1);
    repeat (6) step(1'b1, 1'b1);
    do_reset(3);
    repeat (10) step(1'b1, 1'b1);
    check("held_after_reset_hold", int'(bus.held), 0);
    check("state_after_reset_hold", int'(bus.state_dbg), 0);
    check("count_after_reset", int'(bus.press_count), 0);
    step(1'b1, 1'b0);
    press_hold(2);
    step(1'b1, 1'b0);
    check("count_first_after_reset", int'(bus.press_count), 1);

    // en drop while in LONG: no release, held falls next cycle
    step(1'b1, 1'b1);
    c = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_PRESS, c + 1);
    push(EV_LONG, c + LONG_CYCLES + 1);
    repeat (6) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("held_before_en_drop", int'(bus.held), 1);
    check("state_long", int'(bus.state_dbg), 3);
    step(1'b1, 1'b1);
    check("held_after_en_drop", int'(bus.held), 0);
    repeat (6) step(1'b1, 1'b1);
    check("state_en_still_high", int'(bus.state_dbg), 0);
    step(1'b1, 1'b0);
    press_hold(1);
    step(1'b1, 1'b0);
    check("count_after_en_drop", int'(bus.press_count), 3);

    // counter wrap from a fresh reset
    do_reset(2);
    step(1'b1, 1'b0);
    for (int i = 0; i < 255; i++) press_hold(1);
    step(1'b1, 1'b0);
    check("count_255", int'(bus.press_count), 255);
    press_hold(1);
    step(1'b1, 1'b0);
    check("count_wrap_0", int'(bus.press_count), 0);
    press_hold(1);
    step(1'b1, 1'b0);
    check("count_wrap_1", int'(bus.press_count), 1);

    repeat (10) step(1'b1, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
